// File: rtl/video_line_capture.sv
// Video line grabber: captures active pixels into a ping-pong line buffer
// and flushes each completed line to DDR one 32-bit word at a time.
module video_line_capture #(
   parameter int          WIDTH     = 256,
   parameter int          HEIGHT    = 224,
   parameter logic [27:0] BASE_ADDR = 28'h0,
   parameter logic [7:0]  ALPHA     = 8'hFF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        ce_pix,
   input  logic        hblank,
   input  logic        vblank,
   input  logic        vs,
   input  logic [23:0] rgb,
   output logic [27:0] ddr_addr,
   output logic [31:0] ddr_din,
   output logic        ddr_req,
   input  logic        ddr_ready,
   output logic        busy,
   output logic        overflow,
   output logic [9:0]  line_count
);

   localparam int AW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, READ, REQ, WAIT} state_t;

   state_t state_q, state_d;

   logic [31:0]   buf_mem [0:2*WIDTH-1];
   logic [31:0]   buf_q;
   logic          wbank;
   logic          flush_bank;
   logic [9:0]    flush_line;
   logic [AW:0]   px;
   logic [AW-1:0] word;
   logic          armed;
   logic          vs_d;
   logic          hb_d;
   logic          frame_start;
   logic          line_end;
   logic          cap_en;
   logic          word_last;
   logic [27:0]   line_off;
   logic [27:0]   word_off;

   assign frame_start = ce_pix & vs & ~vs_d;
   assign line_end    = ce_pix & hblank & ~hb_d & (px != '0) & ~frame_start;
   assign cap_en      = ce_pix & ~(hblank | vblank) & armed & ~frame_start
                      & (line_count < 10'(HEIGHT)) & ~px[AW];
   assign word_last   = (word == AW'(WIDTH - 1));
   assign line_off    = 28'(flush_line) << (AW + 2);
   assign word_off    = 28'(word) << 2;
   assign busy        = (state_q != IDLE);

   // Line buffer: no reset, registered read port
   always_ff @(posedge clk) begin
      if (cap_en)
         buf_mem[{wbank, px[AW-1:0]}] <= {ALPHA, rgb};
      buf_q <= buf_mem[{flush_bank, word}];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         vs_d       <= 1'b0;
         hb_d       <= 1'b0;
         armed      <= 1'b0;
         px         <= '0;
         line_count <= '0;
         overflow   <= 1'b0;
         wbank      <= 1'b0;
         flush_bank <= 1'b0;
         flush_line <= '0;
      end else begin
         if (ce_pix) begin
            vs_d <= vs;
            hb_d <= hblank;
         end
         if (frame_start) begin
            px         <= '0;
            line_count <= '0;
            overflow   <= 1'b0;
            armed      <= enable;
         end else if (line_end) begin
            px         <= '0;
            line_count <= line_count + 10'd1;
            // A busy flusher means this line is lost; keep writing the same bank
            if (state_q == IDLE) begin
               flush_bank <= wbank;
               flush_line <= line_count;
               wbank      <= ~wbank;
            end else begin
               overflow <= 1'b1;
            end
         end else if (cap_en) begin
            px <= px + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         word     <= '0;
         ddr_req  <= 1'b0;
         ddr_addr <= '0;
         ddr_din  <= '0;
      end else begin
         state_q <= state_d;
         ddr_req <= (state_q == REQ);
         if (state_q == REQ) begin
            ddr_din  <= buf_q;
            ddr_addr <= BASE_ADDR + line_off + word_off;
         end
         if (state_q == WAIT && ddr_ready)
            word <= word_last ? '0 : word + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (line_end) state_d = READ;
         READ: state_d = REQ;
         REQ:  state_d = WAIT;
         WAIT: if (ddr_ready) state_d = word_last ? IDLE : READ;
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_video_line_capture.sv
// Scoreboard bench for video_line_capture (WIDTH=4, BASE_ADDR=0x1000).
// Stimulus pushes expected DDR writes; a monitor pops them on each ddr_req.
module tb_video_line_capture;

   typedef struct packed {
      logic [27:0] a;
      logic [31:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        ce_pix;
   logic        hblank;
   logic        vblank;
   logic        vs;
   logic [23:0] rgb;
   logic [27:0] ddr_addr;
   logic [31:0] ddr_din;
   logic        ddr_req;
   logic        ddr_ready;
   logic        busy;
   logic        overflow;
   logic [9:0]  line_count;

   exp_t        exp_q[$];
   logic [23:0] pix [0:7];
   int          checks = 0;
   int          errors = 0;
   int          req_cnt = 0;
   int          r0;
   bit          stall = 1'b0;
   bit          pend = 1'b0;

   video_line_capture #(
      .WIDTH(4), .HEIGHT(8), .BASE_ADDR(28'h1000), .ALPHA(8'hFF)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .ce_pix(ce_pix),
      .hblank(hblank), .vblank(vblank), .vs(vs), .rgb(rgb),
      .ddr_addr(ddr_addr), .ddr_din(ddr_din), .ddr_req(ddr_req),
      .ddr_ready(ddr_ready), .busy(busy), .overflow(overflow),
      .line_count(line_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic h, input logic v, input logic s,
                       input logic [23:0] p);
      hblank = h; vblank = v; vs = s; rgb = p;
      ce_pix = 1'b1;
      tick();
      ce_pix = 1'b0;
      tick();
   endtask

   task automatic new_frame();
      step(1'b0, 1'b1, 1'b1, 24'h0);
      step(1'b0, 1'b1, 1'b0, 24'h0);
   endtask

   task automatic send_line(input int n, input int ln, input bit push);
      for (int i = 0; i < n; i++) begin
         if (push && i < 4)
            exp_q.push_back({28'h1000 + 28'(ln * 16 + i * 4),
                             {8'hFF, pix[i]}});
         step(1'b0, 1'b0, 1'b0, pix[i]);
      end
      step(1'b1, 1'b0, 1'b0, 24'h0);
      step(1'b1, 1'b0, 1'b0, 24'h0);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 300) begin
         tick();
         k++;
      end
      chk("flush_done", {31'b0, busy}, 32'h0);
      chk("queue_drained", exp_q.size(), 32'h0);
   endtask

   // Monitor: every DDR request must match the head of the scoreboard
   initial forever begin
      @(negedge clk);
      if (reset_n && ddr_req) begin
         req_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req addr %h data %h", ddr_addr, ddr_din);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ddr_addr", {4'h0, ddr_addr}, {4'h0, e.a});
            chk("ddr_din", ddr_din, e.d);
         end
      end
   end

   // DDR model: accept each request three cycles later unless stalled
   initial begin
      ddr_ready = 1'b0;
      forever begin
         tick();
         if (ddr_req) pend = 1'b1;
         if (pend && !stall) begin
            repeat (2) tick();
            ddr_ready = 1'b1;
            tick();
            ddr_ready = 1'b0;
            pend = 1'b0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; enable = 1'b0; ce_pix = 1'b0;
      hblank = 1'b0; vblank = 1'b1; vs = 1'b0; rgb = '0;
      repeat (3) tick();
      chk("rst_req", {31'b0, ddr_req}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_ovf", {31'b0, overflow}, 32'h0);
      chk("rst_lines", {22'b0, line_count}, 32'h0);
      chk("rst_addr", {4'h0, ddr_addr}, 32'h0);
      chk("rst_din", ddr_din, 32'h0);
      reset_n = 1'b1;
      enable = 1'b1;
      tick();

      new_frame();
      pix[0] = 24'h112233; pix[1] = 24'h445566;
      pix[2] = 24'h778899; pix[3] = 24'hAABBCC;
      send_line(4, 0, 1'b1);
      chk("line0_count", {22'b0, line_count}, 32'd1);
      wait_idle();
      chk("line0_ovf", {31'b0, overflow}, 32'h0);

      pix[0] = 24'h010203; pix[1] = 24'h040506;
      pix[2] = 24'h070809; pix[3] = 24'h0A0B0C;
      send_line(4, 1, 1'b1);
      wait_idle();
      chk("line1_count", {22'b0, line_count}, 32'd2);

      new_frame();
      chk("frame_count", {22'b0, line_count}, 32'd0);
      r0 = req_cnt;
      pix[0] = 24'hC00001; pix[1] = 24'hC00002; pix[2] = 24'hC00003;
      pix[3] = 24'hC00004; pix[4] = 24'hC00005; pix[5] = 24'hC00006;
      send_line(6, 0, 1'b1);
      wait_idle();
      chk("wide_reqs", req_cnt - r0, 32'd4);
      chk("wide_count", {22'b0, line_count}, 32'd1);

      stall = 1'b1;
      r0 = req_cnt;
      pix[0] = 24'hD00001; pix[1] = 24'hD00002;
      pix[2] = 24'hD00003; pix[3] = 24'hD00004;
      send_line(4, 1, 1'b1);
      pix[0] = 24'hE00001; pix[1] = 24'hE00002;
      pix[2] = 24'hE00003; pix[3] = 24'hE00004;
      send_line(4, 2, 1'b0);
      repeat (10) tick();
      chk("ovf_set", {31'b0, overflow}, 32'd1);
      chk("ovf_busy", {31'b0, busy}, 32'd1);
      chk("ovf_count", {22'b0, line_count}, 32'd3);
      chk("ovf_one_req", req_cnt - r0, 32'd1);
      stall = 1'b0;
      wait_idle();
      chk("ovf_reqs", req_cnt - r0, 32'd4);
      chk("ovf_sticky", {31'b0, overflow}, 32'd1);
      new_frame();
      chk("ovf_clear", {31'b0, overflow}, 32'h0);

      enable = 1'b0;
      new_frame();
      r0 = req_cnt;
      send_line(4, 0, 1'b0);
      send_line(4, 1, 1'b0);
      repeat (20) tick();
      chk("dis_count", {22'b0, line_count}, 32'd0);
      chk("dis_reqs", req_cnt - r0, 32'd0);

      enable = 1'b1;
      new_frame();
      stall = 1'b1;
      pix[0] = 24'h123456; pix[1] = 24'h234567;
      pix[2] = 24'h345678; pix[3] = 24'h456789;
      send_line(4, 0, 1'b1);
      send_line(4, 1, 1'b0);
      repeat (4) tick();
      chk("wait_busy", {31'b0, busy}, 32'd1);
      chk("wait_ovf", {31'b0, overflow}, 32'd1);
      reset_n = 1'b0;
      tick();
      tick();
      chk("mid_rst_req", {31'b0, ddr_req}, 32'h0);
      chk("mid_rst_busy", {31'b0, busy}, 32'h0);
      chk("mid_rst_ovf", {31'b0, overflow}, 32'h0);
      chk("mid_rst_addr", {4'h0, ddr_addr}, 32'h0);
      chk("mid_rst_lines", {22'b0, line_count}, 32'h0);
      exp_q.delete();
      reset_n = 1'b1;
      stall = 1'b0;
      r0 = req_cnt;
      send_line(4, 0, 1'b0);
      repeat (20) tick();
      chk("unarmed_reqs", req_cnt - r0, 32'd0);
      chk("unarmed_count", {22'b0, line_count}, 32'd0);

      new_frame();
      pix[0] = 24'h0F0E0D; pix[1] = 24'h0C0B0A;
      pix[2] = 24'h090807; pix[3] = 24'h060504;
      send_line(4, 0, 1'b1);
      wait_idle();
      chk("resume_reqs", req_cnt - r0, 32'd4);
      chk("resume_count", {22'b0, line_count}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
